// File: rtl/fifo_ctrl_lvl.sv
// FIFO pointer/occupancy controller for an external dual-port register file,
// with registered level flags, programmable thresholds and sticky error flags.
module fifo_ctrl_lvl #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr,
    input  logic                  i_rd,
    input  logic                  i_flush,
    input  logic                  i_clr_err,
    output logic [ADDR_WIDTH-1:0] o_w_addr,
    output logic [ADDR_WIDTH-1:0] o_r_addr,
    output logic [ADDR_WIDTH-1:0] o_r_addr_next,
    output logic                  o_w_en,
    output logic                  o_r_en,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_almost_empty,
    output logic                  o_almost_full,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

`ifndef SYNTHESIS
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH) || (AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_param_chk
        $error("fifo_ctrl_lvl: AF_LEVEL or AE_LEVEL outside legal range");
    end
`endif

    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  almost_empty_q, almost_empty_d;
    logic                  almost_full_q, almost_full_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  w_en_s;
    logic                  r_en_s;

    // Acceptance, next pointers/count, flags derived from the next count.
    always_comb begin
        w_en_s         = 1'b0;
        r_en_s         = 1'b0;
        w_addr_d       = w_addr_q;
        r_addr_d       = r_addr_q;
        count_d        = count_q;
        empty_d        = empty_q;
        full_d         = full_q;
        almost_empty_d = almost_empty_q;
        almost_full_d  = almost_full_q;

        // A full FIFO still takes a write when a read frees the slot in the same cycle.
        w_en_s = i_wr & (~full_q | i_rd) & ~i_flush;
        r_en_s = i_rd & ~empty_q & ~i_flush;

        if (i_flush) begin
            w_addr_d = {ADDR_WIDTH{1'b0}};
            r_addr_d = {ADDR_WIDTH{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            w_addr_d = w_addr_q + {{(ADDR_WIDTH-1){1'b0}}, w_en_s};
            r_addr_d = r_addr_q + {{(ADDR_WIDTH-1){1'b0}}, r_en_s};
            count_d  = count_q + {{ADDR_WIDTH{1'b0}}, w_en_s} - {{ADDR_WIDTH{1'b0}}, r_en_s};
        end

        empty_d        = (count_d == {CW{1'b0}});
        full_d         = (count_d == DEPTH_C);
        almost_empty_d = (count_d <= AE_C);
        almost_full_d  = (count_d >= AF_C);

        // Set events take precedence over a concurrent clear; flush leaves errors alone.
        overflow_d  = (i_wr & full_q & ~i_rd) | (overflow_q & ~i_clr_err);
        underflow_d = (i_rd & empty_q) | (underflow_q & ~i_clr_err);
    end

    // State register; reset lands in the same state as a flush with errors cleared.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            w_addr_q       <= {ADDR_WIDTH{1'b0}};
            r_addr_q       <= {ADDR_WIDTH{1'b0}};
            count_q        <= {CW{1'b0}};
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_empty_q <= 1'b1;
            almost_full_q  <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            w_addr_q       <= w_addr_d;
            r_addr_q       <= r_addr_d;
            count_q        <= count_d;
            empty_q        <= empty_d;
            full_q         <= full_d;
            almost_empty_q <= almost_empty_d;
            almost_full_q  <= almost_full_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    assign o_w_addr       = w_addr_q;
    assign o_r_addr       = r_addr_q;
    assign o_r_addr_next  = r_addr_d;
    assign o_w_en         = w_en_s;
    assign o_r_en         = r_en_s;
    assign o_count        = count_q;
    assign o_empty        = empty_q;
    assign o_full         = full_q;
    assign o_almost_empty = almost_empty_q;
    assign o_almost_full  = almost_full_q;
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl_lvl.sv
// Directed bench for fifo_ctrl_lvl: a vector table for fill/drain/error cases,
// then hand-written wrap-around, flush and asynchronous reset sequences.
module tb_fifo_ctrl_lvl;

    logic       i_clk = 1'b0;
    logic       i_reset, i_wr, i_rd, i_flush, i_clr_err;
    logic [3:0] o_w_addr, o_r_addr, o_r_addr_next;
    logic       o_w_en, o_r_en;
    logic [4:0] o_count;
    logic       o_empty, o_full, o_almost_empty, o_almost_full, o_overflow, o_underflow;

    int errors = 0;
    int checks = 0;

    fifo_ctrl_lvl #(.ADDR_WIDTH(4), .AF_LEVEL(15), .AE_LEVEL(1)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_wr(i_wr), .i_rd(i_rd),
        .i_flush(i_flush), .i_clr_err(i_clr_err),
        .o_w_addr(o_w_addr), .o_r_addr(o_r_addr), .o_r_addr_next(o_r_addr_next),
        .o_w_en(o_w_en), .o_r_en(o_r_en), .o_count(o_count),
        .o_empty(o_empty), .o_full(o_full),
        .o_almost_empty(o_almost_empty), .o_almost_full(o_almost_full),
        .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic wr, rd, fl, clr;
        logic wen, ren;
        int   cnt;
        logic e, f, ae, af, ov, un;
        int   wa, ra;
    } vec_t;

    vec_t vq[$];

    // model state for the hand-written sequences
    int cm = 0, wm = 0, rm = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add_v(input logic wr, rd, fl, clr, wen, ren, input int cnt,
                         input logic e, f, ae, af, ov, un, input int wa, ra);
        vec_t v;
        v.wr = wr; v.rd = rd; v.fl = fl; v.clr = clr; v.wen = wen; v.ren = ren;
        v.cnt = cnt; v.e = e; v.f = f; v.ae = ae; v.af = af; v.ov = ov; v.un = un;
        v.wa = wa; v.ra = ra;
        vq.push_back(v);
    endtask

    task automatic drive(input logic wr, rd, fl, clr);
        @(negedge i_clk);
        i_wr = wr; i_rd = rd; i_flush = fl; i_clr_err = clr;
        #1;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, " count"}, 32'(o_count), 32'd0);
        chk({nm, " w_addr"}, 32'(o_w_addr), 32'd0);
        chk({nm, " r_addr"}, 32'(o_r_addr), 32'd0);
        chk({nm, " r_addr_next"}, 32'(o_r_addr_next), 32'd0);
        chk({nm, " empty"}, 32'(o_empty), 32'd1);
        chk({nm, " almost_empty"}, 32'(o_almost_empty), 32'd1);
        chk({nm, " full"}, 32'(o_full), 32'd0);
        chk({nm, " almost_full"}, 32'(o_almost_full), 32'd0);
        chk({nm, " overflow"}, 32'(o_overflow), 32'd0);
        chk({nm, " underflow"}, 32'(o_underflow), 32'd0);
    endtask

    // One cycle against the small occupancy model (depth 16, AE=1, AF=15).
    task automatic mcyc(input string nm, input logic wr, rd);
        logic ew, er;
        drive(wr, rd, 1'b0, 1'b0);
        ew = wr & ((cm < 16) | rd);
        er = rd & (cm > 0);
        chk({nm, " w_en"}, 32'(o_w_en), 32'(ew));
        chk({nm, " r_en"}, 32'(o_r_en), 32'(er));
        tick();
        cm = cm + int'(ew) - int'(er);
        wm = (wm + int'(ew)) % 16;
        rm = (rm + int'(er)) % 16;
        chk({nm, " count"}, 32'(o_count), 32'(cm));
        chk({nm, " w_addr"}, 32'(o_w_addr), 32'(wm));
        chk({nm, " r_addr"}, 32'(o_r_addr), 32'(rm));
        chk({nm, " empty"}, 32'(o_empty), 32'(cm == 0));
        chk({nm, " full"}, 32'(o_full), 32'(cm == 16));
        chk({nm, " almost_empty"}, 32'(o_almost_empty), 32'(cm <= 1));
        chk({nm, " almost_full"}, 32'(o_almost_full), 32'(cm >= 15));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit up;
        i_reset = 1'b1; i_wr = 1'b0; i_rd = 1'b0; i_flush = 1'b0; i_clr_err = 1'b0;
        #2;
        chk_reset_state("reset");
        chk("reset w_en", 32'(o_w_en), 32'd0);
        chk("reset r_en", 32'(o_r_en), 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;

        // fill: after k writes
        for (int k = 1; k <= 16; k++)
            add_v(1, 0, 0, 0, 1, 0, k, 1'b0, k == 16, k <= 1, k >= 15, 0, 0, k % 16, 0);
        // full with wr&rd for three cycles
        add_v(1, 1, 0, 0, 1, 1, 16, 0, 1, 0, 1, 0, 0, 1, 1);
        add_v(1, 1, 0, 0, 1, 1, 16, 0, 1, 0, 1, 0, 0, 2, 2);
        add_v(1, 1, 0, 0, 1, 1, 16, 0, 1, 0, 1, 0, 0, 3, 3);
        // lone write while full: rejected, overflow set
        add_v(1, 0, 0, 0, 0, 0, 16, 0, 1, 0, 1, 1, 0, 3, 3);
        add_v(0, 0, 0, 1, 0, 0, 16, 0, 1, 0, 1, 0, 0, 3, 3);
        // drain: after j reads
        for (int j = 1; j <= 16; j++)
            add_v(0, 1, 0, 0, 0, 1, 16 - j, j == 16, 1'b0, (16 - j) <= 1, (16 - j) >= 15, 0, 0, 3, (3 + j) % 16);
        // empty with wr&rd: write only, underflow set
        add_v(1, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 1, 4, 3);
        add_v(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 4, 3);
        add_v(0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 4, 4);
        // read while empty together with clear: set wins
        add_v(0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 4, 4);
        add_v(0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 4, 4);

        foreach (vq[n]) begin
            string nm;
            nm = $sformatf("vec%0d", n);
            drive(vq[n].wr, vq[n].rd, vq[n].fl, vq[n].clr);
            chk({nm, " w_en"}, 32'(o_w_en), 32'(vq[n].wen));
            chk({nm, " r_en"}, 32'(o_r_en), 32'(vq[n].ren));
            chk({nm, " r_addr_next"}, 32'(o_r_addr_next), 32'(vq[n].ra));
            tick();
            chk({nm, " count"}, 32'(o_count), 32'(vq[n].cnt));
            chk({nm, " empty"}, 32'(o_empty), 32'(vq[n].e));
            chk({nm, " full"}, 32'(o_full), 32'(vq[n].f));
            chk({nm, " almost_empty"}, 32'(o_almost_empty), 32'(vq[n].ae));
            chk({nm, " almost_full"}, 32'(o_almost_full), 32'(vq[n].af));
            chk({nm, " overflow"}, 32'(o_overflow), 32'(vq[n].ov));
            chk({nm, " underflow"}, 32'(o_underflow), 32'(vq[n].un));
            chk({nm, " w_addr"}, 32'(o_w_addr), 32'(vq[n].wa));
            chk({nm, " r_addr"}, 32'(o_r_addr), 32'(vq[n].ra));
        end

        // wrap-around: occupancy bounces between 3 and 8
        cm = 0; wm = 4; rm = 4;
        for (int i = 0; i < 3; i++) mcyc("prefill", 1'b1, 1'b0);
        up = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (cm >= 8) up = 1'b0;
            if (cm <= 3) up = 1'b1;
            if (up) mcyc("wrap", 1'b1, (i % 4) == 3);
            else    mcyc("wrap", (i % 4) == 3, 1'b1);
        end

        // flush at count 9 with a write pending
        while (cm < 9) mcyc("to9", 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush w_en", 32'(o_w_en), 32'd0);
        chk("flush r_en", 32'(o_r_en), 32'd0);
        chk("flush r_addr_next", 32'(o_r_addr_next), 32'd0);
        tick();
        chk_reset_state("flush");
        cm = 0; wm = 0; rm = 0;

        // flush must not clear a sticky error
        mcyc("unf", 1'b0, 1'b1);
        chk("unf set", 32'(o_underflow), 32'd1);
        mcyc("post", 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("flush keeps underflow", 32'(o_underflow), 32'd1);
        chk("flush2 count", 32'(o_count), 32'd0);
        cm = 0; wm = 0; rm = 0;

        // asynchronous reset mid-cycle at count 5
        for (int i = 0; i < 5; i++) mcyc("to5", 1'b1, 1'b0);
        chk("pre-reset count", 32'(o_count), 32'd5);
        @(negedge i_clk);
        i_wr = 1'b1;
        @(posedge i_clk);
        #2;
        i_reset = 1'b1;
        #1;
        chk_reset_state("async");
        @(negedge i_clk);
        i_wr = 1'b0;
        i_reset = 1'b0;
        tick();
        chk("after release count", 32'(o_count), 32'd0);
        chk("after release empty", 32'(o_empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
